instr_dec_pipe: RTL
===================

Name: instr_dec_pipe

Overview:
- Registered, parametrised MIPS instruction decode stage sitting between the IF stage and the EX/control unit.
- Decodes each 32-bit instruction into a one-hot instruction index. Bits 0..30 carry the 31-instruction base set; an optional extension adds mult/div/hi-lo/jalr.
- Unmatched encodings are flagged as illegal, and the stage keeps a saturating count of them.
- A valid/ready handshake with a 2-entry skid buffer lets the stage stall without combinational ready paths; a flush input discards in-flight entries.

Parameters:
- EXT_EN, 0: 1 enables extended instructions at index bits 31..39.
- IDX_W, (EXT_EN ? 40 : 31): width of the one-hot index (derived; never overridden).
- PC_W, 32: width of the PC carried alongside each instruction.
- CNT_W, 16: width of the illegal-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- in_instr  in  32  instruction word
- in_pc  in  PC_W  PC of in_instr
- flush  in  1  discard all held entries
- out_valid  out  1  decoded entry available
- out_ready  in  1  downstream accepts
- out_index  out  IDX_W  one-hot decode, all-zero if illegal
- out_illegal  out  1  encoding matched nothing
- out_instr  out  32  original word, for field extraction downstream
- out_pc  out  PC_W  PC of out_instr
- ill_cnt  out  CNT_W  saturating count of illegal entries delivered

Behaviour:
- Decode key:
  - key = {instr[31:26], instr[5:0]}.
  - For opcode 000000, the funct bits select the instruction. For any other opcode, funct is don't-care.
- Base index map:
  - 0 add, 1 addu, 2 sub, 3 subu, 4 and, 5 or, 6 xor, 7 nor, 8 slt, 9 sltu.
  - 10 sll, 11 srl, 12 sra, 13 sllv, 14 srlv, 15 srav, 16 jr.
  - 17 addi, 18 addiu, 19 andi, 20 ori, 21 xori, 22 lw, 23 sw, 24 beq, 25 bne.
  - 26 slti, 27 sltiu, 28 lui, 29 j, 30 jal.
- Extended index map (EXT_EN=1), funct codes with opcode 000000:
  - 31 mult 011000, 32 multu 011001, 33 div 011010, 34 divu 011011.
  - 35 mfhi 010000, 36 mflo 010010, 37 mthi 010001, 38 mtlo 010011.
  - 39 jalr 001001.
  - With EXT_EN=0 these encodings are illegal.
- Illegal encodings: out_index is all zeros and out_illegal=1; never X. At most one index bit is ever set.
- Decode is computed on in_instr before registering, so stored entries hold the decoded result.
- Storage:
  - Two entries, main and skid. Each holds {index, illegal, instr, pc}.
  - Accept on in_valid & in_ready; deliver on out_valid & out_ready.
- Transitions (checked in order each cycle):
  - flush=1: main and skid cleared to invalid. The flush takes priority over a same-cycle accept and delivery. ill_cnt is unchanged.
  - Main empty: an accepted entry goes to main.
  - Main full and delivered: skid moves to main if skid is valid; otherwise any accepted entry goes to main.
  - Main full and not delivered: an accepted entry goes to skid.
- Latency and throughput:
  - An entry accepted in cycle N has out_valid=1 in cycle N+1.
  - Throughput is 1/cycle with out_ready held high.
- in_ready:
  - Registered; equals !skid_valid.
  - Drops the cycle after the skid fills and rises the cycle after the skid drains. No input is lost when in_valid is held.
- Output stability: while out_valid & !out_ready, all out_* signals hold their values.
- ill_cnt:
  - Increments by 1 when an illegal entry is delivered.
  - Saturates at 2^CNT_W-1, with no wrap.
- Reset (rst_n=0 at a clk edge):
  - Both entries invalid; out_valid=0, in_ready=1, ill_cnt=0.
  - out_index, out_illegal, out_instr and out_pc all reset to 0.
  - Reset overrides flush and any handshake. Reset mid-stall drops held entries.

Decomposition:
- Package instr_dec_pkg holds:
  - opcode and funct localparams;
  - index-position localparams (IDX_ADD=0 ... IDX_JALR=39);
  - IDX_BASE_W=31 and IDX_EXT_W=40.
- Sub-module instr_dec_core: purely combinational key→{index, illegal} decoder, parametrised by EXT_EN.
- instr_dec_pipe instantiates the core on in_instr and implements the skid buffer and counter.

Test Plan:
- Back-to-back stream, out_ready=1: send add 0x00221820, lw 0x8C430004, jal 0x0C000010 → out_valid each following cycle; out_index = bit0, bit22, bit30 in that order; pc order preserved.
- Illegal word 0x00000005 (EXT_EN=0) → out_index=0, out_illegal=1, ill_cnt 0→1. mult 0x00430018 is also illegal. With EXT_EN=1, mult gives index bit31 and out_illegal=0.
- Backpressure: out_ready=0 for 3 cycles while sending 3 instructions → main and skid fill, in_ready=0 from cycle 2. Outputs stable. On release, the 2 held entries deliver in order and the third is accepted.
- Flush with main and skid full and in_valid=1 in the same cycle → next cycle out_valid=0, in_ready=1, the flushed-cycle input is dropped, ill_cnt unchanged.
- Saturation: CNT_W=2, deliver 5 illegal words → ill_cnt reads 1, 2, 3, 3, 3.
- Reset asserted while stalled with 2 entries held → next edge out_valid=0, in_ready=1, ill_cnt=0, out_index=0.

Source files
------------

// File: rtl/instr_dec_pkg.sv
// instr_dec_pkg: MIPS opcode/funct encodings, one-hot index positions and the key decoder.
package instr_dec_pkg;
    localparam int IDX_BASE_W = 31;
    localparam int IDX_EXT_W  = 40;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a,
                           OP_SLTIU = 6'h0b, OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e,
                           OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;

    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04,
                           F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08, F_JALR = 6'h09,
                           F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13,
                           F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1a, F_DIVU = 6'h1b,
                           F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23,
                           F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27,
                           F_SLT = 6'h2a, F_SLTU = 6'h2b;

    localparam int IDX_ADD = 0, IDX_ADDU = 1, IDX_SUB = 2, IDX_SUBU = 3, IDX_AND = 4, IDX_OR = 5,
                   IDX_XOR = 6, IDX_NOR = 7, IDX_SLT = 8, IDX_SLTU = 9, IDX_SLL = 10, IDX_SRL = 11,
                   IDX_SRA = 12, IDX_SLLV = 13, IDX_SRLV = 14, IDX_SRAV = 15, IDX_JR = 16,
                   IDX_ADDI = 17, IDX_ADDIU = 18, IDX_ANDI = 19, IDX_ORI = 20, IDX_XORI = 21,
                   IDX_LW = 22, IDX_SW = 23, IDX_BEQ = 24, IDX_BNE = 25, IDX_SLTI = 26,
                   IDX_SLTIU = 27, IDX_LUI = 28, IDX_J = 29, IDX_JAL = 30, IDX_MULT = 31,
                   IDX_MULTU = 32, IDX_DIV = 33, IDX_DIVU = 34, IDX_MFHI = 35, IDX_MFLO = 36,
                   IDX_MTHI = 37, IDX_MTLO = 38, IDX_JALR = 39;

    // Returns the index bit position for {opcode, funct}, or -1 for an illegal encoding.
    function automatic int dec_pos(input logic [5:0] op, input logic [5:0] fn, input bit ext);
        int p;
        p = -1;
        if (op == OP_SPECIAL) begin
            case (fn)
                F_ADD:   p = IDX_ADD;
                F_ADDU:  p = IDX_ADDU;
                F_SUB:   p = IDX_SUB;
                F_SUBU:  p = IDX_SUBU;
                F_AND:   p = IDX_AND;
                F_OR:    p = IDX_OR;
                F_XOR:   p = IDX_XOR;
                F_NOR:   p = IDX_NOR;
                F_SLT:   p = IDX_SLT;
                F_SLTU:  p = IDX_SLTU;
                F_SLL:   p = IDX_SLL;
                F_SRL:   p = IDX_SRL;
                F_SRA:   p = IDX_SRA;
                F_SLLV:  p = IDX_SLLV;
                F_SRLV:  p = IDX_SRLV;
                F_SRAV:  p = IDX_SRAV;
                F_JR:    p = IDX_JR;
                F_MULT:  p = ext ? IDX_MULT : -1;
                F_MULTU: p = ext ? IDX_MULTU : -1;
                F_DIV:   p = ext ? IDX_DIV : -1;
                F_DIVU:  p = ext ? IDX_DIVU : -1;
                F_MFHI:  p = ext ? IDX_MFHI : -1;
                F_MFLO:  p = ext ? IDX_MFLO : -1;
                F_MTHI:  p = ext ? IDX_MTHI : -1;
                F_MTLO:  p = ext ? IDX_MTLO : -1;
                F_JALR:  p = ext ? IDX_JALR : -1;
                default: p = -1;
            endcase
        end else begin
            case (op)
                OP_ADDI:  p = IDX_ADDI;
                OP_ADDIU: p = IDX_ADDIU;
                OP_ANDI:  p = IDX_ANDI;
                OP_ORI:   p = IDX_ORI;
                OP_XORI:  p = IDX_XORI;
                OP_LW:    p = IDX_LW;
                OP_SW:    p = IDX_SW;
                OP_BEQ:   p = IDX_BEQ;
                OP_BNE:   p = IDX_BNE;
                OP_SLTI:  p = IDX_SLTI;
                OP_SLTIU: p = IDX_SLTIU;
                OP_LUI:   p = IDX_LUI;
                OP_J:     p = IDX_J;
                OP_JAL:   p = IDX_JAL;
                default:  p = -1;
            endcase
        end
        return p;
    endfunction
endpackage

// File: rtl/instr_dec_core.sv
// instr_dec_core: combinational {opcode, funct} key to one-hot index / illegal flag.
module instr_dec_core
    import instr_dec_pkg::*;
#(
    parameter bit EXT_EN = 1'b0,
    parameter int IDX_W  = EXT_EN ? IDX_EXT_W : IDX_BASE_W
) (
    input  logic [11:0]      key_i,
    output logic [IDX_W-1:0] index_o,
    output logic             illegal_o
);
    int pos;

    always_comb begin
        pos       = dec_pos(key_i[11:6], key_i[5:0], EXT_EN);
        illegal_o = pos < 0;
        index_o   = illegal_o ? '0 : IDX_W'(1) << pos;
    end
endmodule

// File: rtl/instr_dec_pipe.sv
// instr_dec_pipe: registered decode stage with a 2-entry skid buffer and a saturating
// illegal-instruction counter.
module instr_dec_pipe
    import instr_dec_pkg::*;
#(
    parameter bit EXT_EN = 1'b0,
    parameter int IDX_W  = EXT_EN ? IDX_EXT_W : IDX_BASE_W,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_illegal,
    output logic [31:0]      out_instr,
    output logic [PC_W-1:0]  out_pc,
    output logic [CNT_W-1:0] ill_cnt
);
    localparam int E_W = IDX_W + 1 + 32 + PC_W;

    logic [IDX_W-1:0] dec_idx;
    logic             dec_ill;
    logic [E_W-1:0]   in_e, main_q, main_d, skid_q, skid_d;
    logic             main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             acc, dlv;

    instr_dec_core #(.EXT_EN(EXT_EN), .IDX_W(IDX_W)) u_core (
        .key_i    ({in_instr[31:26], in_instr[5:0]}),
        .index_o  (dec_idx),
        .illegal_o(dec_ill)
    );

    assign in_e      = {dec_idx, dec_ill, in_instr, in_pc};
    assign {out_index, out_illegal, out_instr, out_pc} = main_q;
    assign out_valid = main_v_q;
    assign in_ready  = !skid_v_q;
    assign ill_cnt   = cnt_q;
    assign acc       = in_valid && in_ready;
    assign dlv       = main_v_q && out_ready;

    // Skid is only ever valid while main is valid, so refilling main prefers skid over input.
    always_comb begin
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d   = main_q;
        skid_d   = skid_q;
        cnt_d    = cnt_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else begin
            if (dlv && out_illegal && cnt_q != '1) cnt_d = cnt_q + 1'b1;
            if (!main_v_q || dlv) begin
                main_v_d = skid_v_q || acc;
                main_d   = skid_v_q ? skid_q : acc ? in_e : main_q;
                skid_v_d = 1'b0;
            end else if (acc) begin
                skid_v_d = 1'b1;
                skid_d   = in_e;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
            cnt_q    <= '0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule
